// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states
// and the default datapath width.
package alu_share_arbiter_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SRL = 3'd4;
  localparam logic [2:0] ALU_SRA = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_alu_core.sv
// Purely combinational ALU shared by both requesters. Opcodes 6 and 7 are
// illegal: they raise err and force the result to zero.
module alu_core
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] c,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  always_comb begin
    c   = '0;
    err = 1'b0;
    case (op)
      ALU_ADD: c = a + b;
      ALU_SUB: c = a - b;
      ALU_AND: c = a & b;
      ALU_OR:  c = a | b;
      ALU_SRL: c = a >> shamt;
      ALU_SRA: c = $signed(a) >>> shamt;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two valid/ready requesters and
// holds the registered result until the consumer takes it.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant_valid;
  logic             grant_id;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_c;
  logic             alu_err;

  // Grants depend only on state and the request valids, never on rsp_ready.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = RR_EN ? ~last_grant_q : 1'b0;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid & ~grant_id;
  assign req1_ready = grant_valid &  grant_id;

  assign alu_a  = grant_id ? req1_a  : req0_a;
  assign alu_b  = grant_id ? req1_b  : req0_b;
  assign alu_op = grant_id ? req1_op : req0_op;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .c  (alu_c),
    .err(alu_err)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = HOLD;
          last_grant_d = grant_id;
          rsp_valid_d  = 1'b1;
          rsp_id_d     = grant_id;
          rsp_data_d   = alu_c;
          rsp_err_d    = alu_err;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a round-robin instance plus a
// fixed-priority instance sharing stimulus, checked against a result queue.
module tb_alu_share_arbiter;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_ready;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_err;
  logic [31:0] fp_rsp_data;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  logic tb_last;

  alu_share_arbiter #(.WIDTH(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  alu_share_arbiter #(.WIDTH(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_data(fp_rsp_data), .rsp_err(fp_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; sra is built as a logical shift with the sign bits filled in.
  function automatic exp_t ref_op(logic id, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    exp_t        r;
    logic [4:0]  sh;
    logic [31:0] ones;
    ones   = 32'hFFFF_FFFF;
    sh     = b[4:0];
    r.id   = id;
    r.err  = 1'b0;
    r.data = 32'h0;
    case (op)
      3'd0: r.data = a + b;
      3'd1: r.data = a + (~b) + 32'd1;
      3'd2: r.data = a & b;
      3'd3: r.data = a | b;
      3'd4: r.data = a >> sh;
      3'd5: begin
        r.data = a >> sh;
        if (a[31]) r.data = r.data | ~(ones >> sh);
      end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb_q.delete();
    tb_last = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd1;
    req1_op = 3'd0; req1_a = 32'd1; req1_b = 32'd1;
    rsp_ready  = 1'b1;
    #3;
    total++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== 35'h0) begin
      bad++;
      $display("[TB] FAIL reset_rsp: got valid=%b id=%b err=%b data=%h, want all zero",
               rsp_valid, rsp_id, rsp_err, rsp_data);
    end
    total++;
    if ({req1_ready, req0_ready, fp_req1_ready, fp_req0_ready} !== 4'b0) begin
      bad++;
      $display("[TB] FAIL reset_ready: got %b, want 0000",
               {req1_ready, req0_ready, fp_req1_ready, fp_req0_ready});
    end
    do_reset();
  endtask

  task automatic test_single_add();
    exp_t e;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd5; req0_b = 32'd7;
    rsp_ready  = 1'b1;
    @(negedge clk);
    total++;
    if ({req1_ready, req0_ready, rsp_valid} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL add_accept: got r1=%b r0=%b rsp_valid=%b, want 0 1 0",
               req1_ready, req0_ready, rsp_valid);
    end
    sb_q.push_back('{id: 1'b0, err: 1'b0, data: 32'd12});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL add_latency: rsp_valid got %b want 1", rsp_valid);
    end else begin
      e = sb_q.pop_front();
      total++;
      if ({rsp_id, rsp_err, rsp_data} !== e) begin
        bad++;
        $display("[TB] FAIL add_rsp: got id=%b err=%b data=%h want id=%b err=%b data=%h",
                 rsp_id, rsp_err, rsp_data, e.id, e.err, e.data);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL add_release: rsp_valid got %b want 0", rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    exp_t       e;
    logic [1:0] exp_rdy;
    logic       busy, busy_nx;
    do_reset();
    busy = 1'b0;
    req0_op = 3'd1; req0_a = 32'd3;          req0_b = 32'd5;
    req1_op = 3'd5; req1_a = 32'h8000_0000;  req1_b = 32'd4;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      req0_valid = (cyc < 9);
      req1_valid = (cyc < 9);
      @(negedge clk);
      busy_nx = busy;
      exp_rdy = 2'b00;
      if (!busy && req0_valid && req1_valid) exp_rdy = tb_last ? 2'b01 : 2'b10;
      total++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        bad++;
        $display("[TB] FAIL rr_grant: cycle %0d got %b want %b", cyc, {req1_ready, req0_ready}, exp_rdy);
      end
      total++;
      if (rsp_valid !== busy) begin
        bad++;
        $display("[TB] FAIL rr_valid: cycle %0d got %b want %b", cyc, rsp_valid, busy);
      end
      if (rsp_valid && rsp_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if ({rsp_id, rsp_err, rsp_data} !== e) begin
          bad++;
          $display("[TB] FAIL rr_rsp: got id=%b err=%b data=%h want id=%b err=%b data=%h",
                   rsp_id, rsp_err, rsp_data, e.id, e.err, e.data);
        end
        busy_nx = 1'b0;
      end
      if (exp_rdy == 2'b01) begin
        sb_q.push_back('{id: 1'b0, err: 1'b0, data: 32'hFFFF_FFFE});
        tb_last = 1'b0; busy_nx = 1'b1;
      end else if (exp_rdy == 2'b10) begin
        sb_q.push_back('{id: 1'b1, err: 1'b0, data: 32'hF800_0000});
        tb_last = 1'b1; busy_nx = 1'b1;
      end
      busy = busy_nx;
      @(posedge clk); #1;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL rr_drain: %0d results outstanding, want 0", sb_q.size());
    end
  endtask

  task automatic test_fixed_priority();
    logic busy;
    int   grants;
    do_reset();
    busy   = 1'b0;
    grants = 0;
    req0_op = 3'd0; req0_a = 32'd10; req0_b = 32'd20;
    req1_op = 3'd2; req1_a = 32'hFF;  req1_b = 32'h0F;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      req0_valid = (cyc < 8);
      req1_valid = (cyc < 8);
      @(negedge clk);
      total++;
      if ({fp_req1_ready, fp_req0_ready} !== ((!busy && req0_valid) ? 2'b01 : 2'b00)) begin
        bad++;
        $display("[TB] FAIL fp_grant: cycle %0d got %b want %b", cyc,
                 {fp_req1_ready, fp_req0_ready}, (!busy && req0_valid) ? 2'b01 : 2'b00);
      end
      if (busy) begin
        total++;
        if ({fp_rsp_valid, fp_rsp_id, fp_rsp_err, fp_rsp_data} !== {3'b100, 32'd30}) begin
          bad++;
          $display("[TB] FAIL fp_rsp: got valid=%b id=%b err=%b data=%h want 1 0 0 0000001e",
                   fp_rsp_valid, fp_rsp_id, fp_rsp_err, fp_rsp_data);
        end
        busy = 1'b0;
      end else if (req0_valid) begin
        busy = 1'b1;
        grants++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (grants != 4) begin
      bad++;
      $display("[TB] FAIL fp_count: got %0d grants want 4", grants);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'hF000_0000; req1_b = 32'd28;
    rsp_ready  = 1'b0;
    @(negedge clk);
    total++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL bp_accept: got %b want 10", {req1_ready, req0_ready});
    end
    sb_q.push_back('{id: 1'b1, err: 1'b0, data: 32'h0000_000F});
    @(posedge clk); #1;
    req0_valid = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_id, rsp_data, req1_ready, req0_ready} !== {2'b11, 32'h0000_000F, 2'b00}) begin
        bad++;
        $display("[TB] FAIL bp_hold: cycle %0d got valid=%b id=%b data=%h rdy=%b want 1 1 0000000f 00",
                 cyc, rsp_valid, rsp_id, rsp_data, {req1_ready, req0_ready});
      end
      @(posedge clk); #1;
    end
    rsp_ready  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_release_valid: got %b want 1", rsp_valid);
    end else begin
      e = sb_q.pop_front();
      total++;
      if ({rsp_id, rsp_err, rsp_data} !== e) begin
        bad++;
        $display("[TB] FAIL bp_rsp: got id=%b err=%b data=%h want id=%b err=%b data=%h",
                 rsp_id, rsp_err, rsp_data, e.id, e.err, e.data);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_idle: rsp_valid got %b want 0", rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_op();
    req0_valid = 1'b1; req0_op = 3'd6; req0_a = 32'd1; req0_b = 32'd1;
    rsp_ready  = 1'b1;
    @(negedge clk);
    total++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL ill_accept: got %b want 01", {req1_ready, req0_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b101, 32'h0}) begin
      bad++;
      $display("[TB] FAIL ill_rsp: got valid=%b id=%b err=%b data=%h want 1 0 1 00000000",
               rsp_valid, rsp_id, rsp_err, rsp_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ill_release: rsp_valid got %b want 0", rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd1;
    rsp_ready  = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rmid_hold: rsp_valid got %b want 1", rsp_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, rsp_data} !== 33'h0) begin
      bad++;
      $display("[TB] FAIL rmid_async: got valid=%b data=%h want 0 00000000", rsp_valid, rsp_data);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd2; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 3'd3; req1_a = 32'd8; req1_b = 32'd1;
    rsp_ready  = 1'b1;
    @(negedge clk);
    total++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL rmid_first_grant: got %b want 01", {req1_ready, req0_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b100, 32'd4}) begin
      bad++;
      $display("[TB] FAIL rmid_rsp: got valid=%b id=%b err=%b data=%h want 1 0 0 00000004",
               rsp_valid, rsp_id, rsp_err, rsp_data);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_random_ops();
    exp_t       e;
    logic [1:0] exp_rdy;
    logic       busy, busy_nx;
    do_reset();
    busy = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc < 72) begin
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        rsp_ready  = ($urandom_range(0, 3) != 0);
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
      end
      req0_op = 3'($urandom_range(0, 7)); req0_a = $urandom; req0_b = $urandom;
      req1_op = 3'($urandom_range(0, 7)); req1_a = $urandom; req1_b = $urandom;
      @(negedge clk);
      busy_nx = busy;
      exp_rdy = 2'b00;
      if (!busy) begin
        if (req0_valid && req1_valid) exp_rdy = tb_last ? 2'b01 : 2'b10;
        else exp_rdy = {req1_valid, req0_valid};
      end
      total++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        bad++;
        $display("[TB] FAIL rand_grant: cycle %0d got %b want %b", cyc, {req1_ready, req0_ready}, exp_rdy);
      end
      if (rsp_valid && rsp_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if ({rsp_id, rsp_err, rsp_data} !== e) begin
          bad++;
          $display("[TB] FAIL rand_rsp: cycle %0d got id=%b err=%b data=%h want id=%b err=%b data=%h",
                   cyc, rsp_id, rsp_err, rsp_data, e.id, e.err, e.data);
        end
        busy_nx = 1'b0;
      end
      if (exp_rdy == 2'b01) begin
        sb_q.push_back(ref_op(1'b0, req0_op, req0_a, req0_b));
        tb_last = 1'b0; busy_nx = 1'b1;
      end else if (exp_rdy == 2'b10) begin
        sb_q.push_back(ref_op(1'b1, req1_op, req1_a, req1_b));
        tb_last = 1'b1; busy_nx = 1'b1;
      end
      busy = busy_nx;
      @(posedge clk); #1;
    end
    total++;
    if (sb_q.size() != 0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rand_drain: outstanding=%0d rsp_valid=%b want 0 0", sb_q.size(), rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_illegal_op();
    test_reset_mid_op();
    test_random_ops();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit combinational ALU between two requesters (req0, req1) using valid/ready handshakes.
- Arbitrates round-robin (or fixed priority), captures the operands, and registers the ALU result.
- Holds the result until the winning requester accepts it.
- Sits between the datapath issue logic and the single ALU instance, so two units can time-share one adder/shifter.

Parameters:
- WIDTH, 32, operand/result width; shifts use the low clog2(WIDTH) bits of B.
- RR_EN, 1, 1 = round-robin between requesters; 0 = req0 always has priority.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  3  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req1_valid / req1_ready / req1_op / req1_a / req1_b: same as req0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that owns the result
- rsp_data  out  WIDTH  ALU result
- rsp_err  out  1  opcode was 6 or 7 (illegal); rsp_data = 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, last_grant=1 (so req0 wins first), req*_ready=0.
- FSM states: IDLE, HOLD.
- IDLE:
  - if any reqX_valid, grant one; reqX_ready=1 combinationally for that requester only, in that cycle.
  - The transfer happens in that cycle; the ALU is evaluated on the granted operands.
  - Next edge: rsp_data/rsp_err/rsp_id registered, rsp_valid=1, state -> HOLD.
- HOLD:
  - rsp_* stable while rsp_ready=0.
  - On an edge with rsp_ready=1, go to IDLE and deassert rsp_valid.
  - Requests are not accepted in the release cycle, so throughput is one op per 2 cycles minimum.
  - Both req*_ready=0 in HOLD.
- Latency: accept at cycle N -> rsp_valid at cycle N+1.
- Arbitration:
  - RR_EN=1, both valid: grant the requester not equal to last_grant; last_grant updates on each grant.
  - Single valid: that requester wins regardless of last_grant.
  - RR_EN=0: req0 always wins a tie.
- ALU rules:
  - add/sub are modulo 2^WIDTH, no carry/overflow output.
  - srl is logical; sra is arithmetic, A treated as signed.
  - Shift amount is B[4:0] for WIDTH=32.
  - Ops 6/7: rsp_data=0, rsp_err=1; the request is still consumed and responded to.
- Requesters must hold valid/op/a/b stable until ready. The arbiter does not rely on this, since operands are captured at the accept edge.
- A requester that drops valid before grant loses nothing; no grant is recorded.
- Reset mid-operation: the pending result is discarded, rsp_valid -> 0 immediately (async), and last_grant returns to 1.
- No combinational path from rsp_ready to req*_ready.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SRL=4, ALU_SRA=5.
  - State encoding: IDLE=0, HOLD=1.
  - WIDTH default.
- One natural sub-module: alu_core, a purely combinational ALU (A, B, op -> C, err) instantiated once.
- Arbitration, FSM and output registers live in the top module.

Test Plan:
- Reset, then req0 only: add a=5, b=7 -> req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12, rsp_err=0.
- Both valid every cycle, rsp_ready=1, RR_EN=1: req0 sub 3-5, req1 sra 0x80000000>>4 -> grants alternate 0,1,0,1; rsp_data=0xFFFFFFFE (id0) and 0xF8000000 (id1).
- RR_EN=0, both valid continuously -> req1 never granted; every rsp_id=0.
- Backpressure: req1 srl 0xF0000000 by 28, rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_data=0xF held; req*_ready=0 throughout; after rsp_ready=1, IDLE next cycle.
- Illegal op: req0_op=6, a=1, b=1 -> rsp_err=1, rsp_data=0, handshake completes normally.
- rst_n pulsed low while in HOLD -> rsp_valid=0 immediately, no clock edge needed; after release, both valid -> req0 granted first.
